// File: rtl/narrow_clip_unit.sv
// narrow_clip_unit: two-stage per-lane shift/round/clip narrower; NARROW_CLIP_STICKY_EN adds the sticky vxsat flag
module narrow_clip_unit #(
  parameter int W_IN = 16,
  parameter int W_OUT = 8,
  parameter int LANES = 4,
  parameter int W_SH = $clog2(W_IN)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*W_IN-1:0]  in_data,
  input  logic [W_SH-1:0]        in_shamt,
  input  logic [1:0]             in_vxrm,
  input  logic                   in_signed,
  input  logic [LANES-1:0]       in_lane_en,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*W_OUT-1:0] out_data,
  output logic [LANES-1:0]       out_sat,
  output logic                   vxsat,
  input  logic                   vxsat_clr
);
  localparam logic signed [W_IN:0] s_hi = (W_IN+1)'(2**(W_OUT-1)-1);
  localparam logic signed [W_IN:0] s_lo = (W_IN+1)'(-(2**(W_OUT-1)));
  localparam logic signed [W_IN:0] u_hi = (W_IN+1)'(2**W_OUT-1);
  logic s1_v, s2_v, s1_sg, ready2;
  logic [LANES-1:0] s1_en, clip_sat;
  logic [LANES*W_OUT-1:0] clip_data;
  logic [W_IN-1:0] mask;
  assign ready2 = !s2_v | out_ready;
  assign in_ready = !s1_v | ready2;
  assign out_valid = s2_v;
  assign mask = (W_IN'(1) << in_shamt) - W_IN'(1);
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [W_IN-1:0] v;
    logic signed [W_IN:0] sh, s1_val;
    logic bd, bd1, lo_any, below, r, over, under;
    assign v = in_data[i*W_IN +: W_IN];
    assign sh = $signed({in_signed & v[W_IN-1], v}) >>> in_shamt;
    // bd1 is the bit just below the cut, lo_any the sticky bits under it
    assign bd = v[in_shamt];
    assign bd1 = |(v & mask & ~(mask >> 1));
    assign lo_any = |(v & (mask >> 1));
    assign below = |(v & mask);
    assign r = in_vxrm == 2'd0 ? bd1 :
               in_vxrm == 2'd1 ? bd1 & (lo_any | bd) :
               in_vxrm == 2'd2 ? 1'b0 : !bd & below;
    always_ff @(posedge clk)
      if (reset) s1_val <= '0;
      else if (in_valid & in_ready) s1_val <= sh + (W_IN+1)'(r);
    assign over = s1_val > (s1_sg ? s_hi : u_hi);
    assign under = s1_sg && s1_val < s_lo;
    assign clip_sat[i] = s1_en[i] & (over | under);
    assign clip_data[i*W_OUT +: W_OUT] = !s1_en[i] ? '0 :
                                         over ? (s1_sg ? s_hi[W_OUT-1:0] : u_hi[W_OUT-1:0]) :
                                         under ? s_lo[W_OUT-1:0] : s1_val[W_OUT-1:0];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s1_sg <= 1'b0;
      s1_en <= '0;
      out_data <= '0;
      out_sat <= '0;
    end else begin
      if (in_ready) s1_v <= in_valid;
      if (in_valid & in_ready) begin
        s1_sg <= in_signed;
        s1_en <= in_lane_en;
      end
      if (ready2) s2_v <= s1_v;
      if (ready2 & s1_v) begin
        out_data <= clip_data;
        out_sat <= clip_sat;
      end
    end
  end
`ifdef NARROW_CLIP_STICKY_EN
  always_ff @(posedge clk)
    vxsat <= reset ? 1'b0 : (out_valid & out_ready & |out_sat) | (vxsat & !vxsat_clr);
`else
  logic unused_clr;
  assign unused_clr = vxsat_clr;
  assign vxsat = 1'b0;
`endif
endmodule

// File: tb/tb_narrow_clip_unit.sv
// tb_narrow_clip_unit: randomized and directed checks of narrow_clip_unit against an arithmetic reference model
module tb_narrow_clip_unit;
  logic clk = 0, reset = 1, in_valid = 0, in_signed = 0, out_ready = 1, vxsat_clr = 0;
  logic [63:0] in_data = '0;
  logic [3:0] in_shamt = '0, in_lane_en = '1;
  logic [1:0] in_vxrm = '0;
  logic in_ready, out_valid, vxsat;
  logic [31:0] out_data;
  logic [3:0] out_sat;
`ifdef NARROW_CLIP_STICKY_EN
  localparam bit sticky = 1'b1;
`else
  localparam bit sticky = 1'b0;
`endif
  int n_vec = 0, n_err = 0, cyc_n = 0, last_lat = 0, idx;
  bit last_acc, stall_prev, vx_m;
  logic [35:0] held, last_res, e;
  logic [35:0] exp_q[$];
  int acc_q[$];
  logic [7:0] tbl[4] = '{8'h03, 8'h02, 8'h02, 8'h03};

  narrow_clip_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_shamt(in_shamt), .in_vxrm(in_vxrm), .in_signed(in_signed), .in_lane_en(in_lane_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .vxsat(vxsat), .vxsat_clr(vxsat_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // floor-divide, then round by the remainder against half an LSB
  function automatic logic [8:0] ref_lane(logic [15:0] v, int d, int mode, bit sg, bit en);
    longint x, p, q, rem, y, hi, lo;
    bit r, s;
    x = sg ? longint'($signed(v)) : longint'(v);
    p = longint'(1) << d;
    q = x >= 0 ? x / p : -((-x + p - 1) / p);
    rem = x - q * p;
    case (mode)
      0: r = rem * 2 >= p;
      1: r = rem * 2 > p || (rem * 2 == p && q % 2 != 0);
      2: r = 0;
      default: r = rem != 0 && q % 2 == 0;
    endcase
    y = q + longint'(r);
    hi = sg ? 127 : 255;
    lo = sg ? -128 : 0;
    s = y > hi || y < lo;
    y = y > hi ? hi : y < lo ? lo : y;
    return en ? {s, y[7:0]} : 9'd0;
  endfunction

  function automatic logic [35:0] model();
    logic [35:0] m;
    logic [8:0] l;
    m = '0;
    for (int k = 0; k < 4; k++) begin
      l = ref_lane(in_data[k*16 +: 16], int'(in_shamt), int'(in_vxrm), in_signed, in_lane_en[k]);
      m[32+k] = l[8];
      m[k*8 +: 8] = l[7:0];
    end
    return m;
  endfunction

  task automatic cyc();
    @(negedge clk);
    cyc_n++;
    last_acc = 0;
    e = '0;
    if (reset) begin
      exp_q.delete();
      acc_q.delete();
      vx_m = 0;
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 64'(out_valid), 1);
        chk("hold_data", 64'({out_sat, out_data}), 64'(held));
      end
      chk("vxsat", 64'(vxsat), 64'(vx_m));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("q_empty", 0, 1);
        else begin
          e = exp_q.pop_front();
          chk("beat", 64'({out_sat, out_data}), 64'(e));
          last_res = {out_sat, out_data};
          last_lat = cyc_n - acc_q.pop_front();
        end
      end
      if (sticky) begin
        if (out_valid && out_ready && |e[35:32]) vx_m = 1;
        else if (vxsat_clr) vx_m = 0;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model());
        acc_q.push_back(cyc_n);
        last_acc = 1;
      end
      stall_prev = out_valid && !out_ready;
      held = {out_sat, out_data};
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(logic [63:0] d, logic [3:0] sh, logic [1:0] rm, bit sg, logic [3:0] en);
    in_valid = 1;
    in_data = d;
    in_shamt = sh;
    in_vxrm = rm;
    in_signed = sg;
    in_lane_en = en;
  endtask

  task automatic run1(logic [63:0] d, logic [3:0] sh, logic [1:0] rm, bit sg, logic [3:0] en);
    out_ready = 1;
    set_in(d, sh, rm, sg, en);
    last_acc = 0;
    for (int k = 0; k < 20 && !last_acc; k++) cyc();
    in_valid = 0;
    chk("accepted", 64'(last_acc), 1);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) cyc();
    chk("drained", 64'(exp_q.size()), 0);
  endtask

  task automatic rnd_beat();
    set_in({$urandom, $urandom}, 4'($urandom), 2'($urandom), 1'($urandom), 4'($urandom));
  endtask

  initial begin
    cyc();
    cyc();
    reset = 0;
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_data", 64'(out_data), 0);
    chk("rst_sat", 64'(out_sat), 0);
    chk("rst_vxsat", 64'(vxsat), 0);
    chk("rst_ready", 64'(in_ready), 1);
    run1({16'hFF80, 16'h007F, 16'hFF00, 16'h0100}, 0, 0, 1, 4'hF);
    chk("clip_signed", 64'(last_res), 64'({4'b0011, 32'h807F807F}));
    chk("latency", 64'(last_lat), 2);
    chk("vx_set", 64'(vxsat), 64'(sticky));
    for (int m = 0; m < 4; m++) begin
      run1({16'h0, 16'h0, 16'h0018, 16'h0028}, 4, 2'(m), 1, 4'hF);
      chk("round_mode", 64'(last_res[7:0]), 64'(tbl[m]));
      if (m == 1) chk("rne_tie_odd", 64'(last_res[15:8]), 64'h02);
    end
    run1({16'h0, 16'h0, 16'h7F00, 16'hFFFF}, 8, 0, 0, 4'hF);
    chk("uns_lane0", 64'(last_res[7:0]), 64'hFF);
    chk("uns_lane1", 64'(last_res[15:8]), 64'h7F);
    chk("uns_sat", 64'(last_res[33:32]), 64'h1);
    run1({16'h0, 16'h0, 16'h7F00, 16'hFFFF}, 8, 0, 0, 4'hE);
    chk("masked_data", 64'(last_res[7:0]), 0);
    chk("masked_sat", 64'(last_res[32]), 0);
    out_ready = 0;
    idx = 0;
    for (int k = 0; k < 4; k++) begin
      if (idx < 3) rnd_beat(); else in_valid = 0;
      cyc();
      if (last_acc) idx++;
    end
    chk("stall_acc", 64'(idx), 2);
    chk("stall_ready", 64'(in_ready), 0);
    out_ready = 1;
    for (int k = 0; k < 20 && idx < 3; k++) begin
      rnd_beat();
      cyc();
      if (last_acc) idx++;
    end
    in_valid = 0;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) cyc();
    chk("stall_drained", 64'(exp_q.size()), 0);
    out_ready = 0;
    set_in({48'h0, 16'h0100}, 0, 0, 1, 4'hF);
    last_acc = 0;
    for (int k = 0; k < 20 && !last_acc; k++) cyc();
    in_valid = 0;
    for (int k = 0; k < 10 && !out_valid; k++) cyc();
    chk("sat_pending", 64'(out_valid), 1);
    vxsat_clr = 1;
    out_ready = 1;
    cyc();
    vxsat_clr = 0;
    chk("vx_coincide", 64'(vxsat), 64'(sticky));
    vxsat_clr = 1;
    cyc();
    vxsat_clr = 0;
    chk("vx_clear", 64'(vxsat), 0);
    out_ready = 0;
    idx = 0;
    for (int k = 0; k < 10 && idx < 2; k++) begin
      set_in({48'h0, 16'h0100}, 0, 0, 1, 4'hF);
      cyc();
      if (last_acc) idx++;
    end
    in_valid = 0;
    reset = 1;
    cyc();
    reset = 0;
    chk("flush_valid", 64'(out_valid), 0);
    chk("flush_data", 64'({out_sat, out_data}), 0);
    chk("flush_vxsat", 64'(vxsat), 0);
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk("flush_quiet", 64'(out_valid), 0);
    end
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(3) != 0) rnd_beat(); else in_valid = 0;
      out_ready = $urandom_range(3) != 0;
      vxsat_clr = $urandom_range(7) == 0;
      cyc();
    end
    in_valid = 0;
    vxsat_clr = 0;
    out_ready = 1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) cyc();
    chk("final_drained", 64'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
